// File: rtl/updown_seq_monitor_3bit.sv
// Watches a 3-bit up/down counter (q, qbar) and flags illegal steps, wraps and complement errors.
// Define COMP_CHECK_EN to enable the qbar == ~q check; otherwise comp_err stays 0.
module updown_seq_monitor_3bit #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2:0]           q,
    input  logic [2:0]           qbar,
    output logic                 dir,
    output logic                 dir_valid,
    output logic                 step_err,
    output logic                 comp_err,
    output logic                 wrap_up,
    output logic                 wrap_down,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        StInit = 3'd0,
        StHold = 3'd1,
        StUp   = 3'd2,
        StDown = 3'd3,
        StErr  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           q_prev_q, q_prev_d;
    logic                 dir_q, dir_d;
    logic                 dir_valid_q, dir_valid_d;
    logic                 step_err_q, step_err_d;
    logic                 comp_err_q, comp_err_d;
    logic                 wrap_up_q, wrap_up_d;
    logic                 wrap_down_q, wrap_down_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [2:0]           delta;
    logic                 comp_mismatch;
    logic [ERR_CNT_W:0]   cnt_sum;

`ifdef COMP_CHECK_EN
    assign comp_mismatch = (qbar != ~q);
`else
    logic unused_qbar;
    assign unused_qbar   = ^qbar;
    assign comp_mismatch = 1'b0;
`endif

    assign delta = q - q_prev_q;

    always_comb begin
        state_d     = state_q;
        q_prev_d    = q_prev_q;
        dir_d       = dir_q;
        dir_valid_d = dir_valid_q;
        step_err_d  = 1'b0;
        comp_err_d  = 1'b0;
        wrap_up_d   = 1'b0;
        wrap_down_d = 1'b0;
        if (en) begin
            q_prev_d   = q;
            comp_err_d = comp_mismatch;
            if (state_q == StInit) begin
                state_d = StHold;
            end else begin
                case (delta)
                    3'd0: state_d = StHold;
                    3'd1: begin
                        state_d     = StUp;
                        dir_d       = 1'b1;
                        dir_valid_d = 1'b1;
                        wrap_up_d   = (q_prev_q == 3'd7);
                    end
                    3'd7: begin
                        state_d     = StDown;
                        dir_d       = 1'b0;
                        dir_valid_d = 1'b1;
                        wrap_down_d = (q_prev_q == 3'd0);
                    end
                    default: begin
                        state_d    = StErr;
                        step_err_d = 1'b1;
                    end
                endcase
            end
        end
        // One extra bit catches overflow so the counter clamps instead of wrapping.
        cnt_sum = {1'b0, err_cnt_q} + {{ERR_CNT_W{1'b0}}, step_err_d}
                + {{ERR_CNT_W{1'b0}}, comp_err_d};
        if (cnt_sum[ERR_CNT_W]) begin
            err_cnt_d = '1;
        end else begin
            err_cnt_d = cnt_sum[ERR_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            q_prev_q    <= 3'd0;
            dir_q       <= 1'b0;
            dir_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            comp_err_q  <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            q_prev_q    <= q_prev_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            step_err_q  <= step_err_d;
            comp_err_q  <= comp_err_d;
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign state     = state_q;
    assign dir       = dir_q;
    assign dir_valid = dir_valid_q;
    assign step_err  = step_err_q;
    assign comp_err  = comp_err_q;
    assign wrap_up   = wrap_up_q;
    assign wrap_down = wrap_down_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_updown_seq_monitor_3bit.sv
// Scoreboard bench for updown_seq_monitor_3bit: directed vectors with hand-computed expectations.
// A second instance with ERR_CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_updown_seq_monitor_3bit;

`ifdef COMP_CHECK_EN
    localparam int C = 1;
`else
    localparam int C = 0;
`endif

    typedef struct {
        int st;
        int dir;
        int dv;
        int se;
        int ce;
        int wu;
        int wd;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] q = 3'd0;
    logic [2:0] qbar = 3'd7;

    logic       dir, dir_valid, step_err, comp_err, wrap_up, wrap_down;
    logic [7:0] err_cnt;
    logic [2:0] state;

    logic       dir2, dir_valid2, step_err2, comp_err2, wrap_up2, wrap_down2;
    logic [1:0] err_cnt2;
    logic [2:0] state2;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    updown_seq_monitor_3bit dut (
        .clk(clk), .rst(rst), .en(en), .q(q), .qbar(qbar),
        .dir(dir), .dir_valid(dir_valid), .step_err(step_err), .comp_err(comp_err),
        .wrap_up(wrap_up), .wrap_down(wrap_down), .err_cnt(err_cnt), .state(state)
    );

    updown_seq_monitor_3bit #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .q(q), .qbar(qbar),
        .dir(dir2), .dir_valid(dir_valid2), .step_err(step_err2), .comp_err(comp_err2),
        .wrap_up(wrap_up2), .wrap_down(wrap_down2), .err_cnt(err_cnt2), .state(state2)
    );

    function automatic exp_t mk(int st, int d, int dv, int se, int ce, int wu, int wd, int cnt);
        exp_t x;
        x.st = st; x.dir = d; x.dv = dv; x.se = se; x.ce = ce;
        x.wu = wu; x.wd = wd; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Drive one sample at negedge; its registered effect is checked after the next posedge.
    task automatic vec(input bit r, input bit e, input logic [2:0] qq, input logic [2:0] qb,
                       input exp_t x);
        @(negedge clk);
        rst  = r;
        en   = e;
        q    = qq;
        qbar = qb;
        sbq.push_back(x);
    endtask

    task automatic vn(input bit r, input bit e, input logic [2:0] qq, input exp_t x);
        vec(r, e, qq, ~qq, x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("state", int'(state), x.st);
                chk("dir", int'(dir), x.dir);
                chk("dir_valid", int'(dir_valid), x.dv);
                chk("step_err", int'(step_err), x.se);
                chk("comp_err", int'(comp_err), x.ce);
                chk("wrap_up", int'(wrap_up), x.wu);
                chk("wrap_down", int'(wrap_down), x.wd);
                chk("err_cnt", int'(err_cnt), x.cnt);
                chk("err_cnt_w2", int'(err_cnt2), (x.cnt > 3) ? 3 : x.cnt);
                chk("state_w2", int'(state2), x.st);
            end
        end
    end

    initial begin : stim
        logic [2:0] ill [5];
        ill[0] = 3'd2; ill[1] = 3'd5; ill[2] = 3'd0; ill[3] = 3'd3; ill[4] = 3'd6;

        // Reset, then full up-count with a 7->0 wrap
        vn(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        vn(0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i < 8; i++) vn(0, 1, 3'(i), mk(2, 1, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 0, mk(2, 1, 1, 0, 0, 1, 0, 0));
        vn(0, 0, 3, mk(2, 1, 1, 0, 0, 0, 0, 0));

        // Up to 3, reverse down through the 0->7 wrap, then hold
        vn(0, 1, 1, mk(2, 1, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 2, mk(2, 1, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 3, mk(2, 1, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 2, mk(3, 0, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 1, mk(3, 0, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 0, mk(3, 0, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 7, mk(3, 0, 1, 0, 0, 0, 1, 0));
        vn(0, 1, 7, mk(1, 0, 1, 0, 0, 0, 0, 0));

        // 2 -> 5 is illegal, 5 -> 6 recovers
        vn(0, 1, 0, mk(2, 1, 1, 0, 0, 1, 0, 0));
        vn(0, 1, 1, mk(2, 1, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 2, mk(2, 1, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 5, mk(4, 1, 1, 1, 0, 0, 0, 1));
        vn(0, 1, 6, mk(2, 1, 1, 0, 0, 0, 0, 1));

        // Reset together with en discards the sample; complement check on first sample
        vn(1, 1, 4, mk(0, 0, 0, 0, 0, 0, 0, 0));
        vec(0, 1, 3, 3'b000, mk(1, 0, 0, 0, C, 0, 0, C));
        vec(0, 1, 6, 3'b000, mk(4, 0, 0, 1, C, 0, 0, 1 + 2 * C));
        vec(0, 1, 7, 3'b000, mk(2, 1, 1, 0, 0, 0, 0, 1 + 2 * C));

        // Five consecutive illegal steps; the 2-bit counter clamps at 3
        for (int k = 0; k < 5; k++) vn(0, 1, ill[k], mk(4, 1, 1, 1, 0, 0, 0, 2 + 2 * C + k));
        vn(0, 0, 1, mk(4, 1, 1, 0, 0, 0, 0, 6 + 2 * C));

        // Reset in the middle of an up-count; history is discarded
        vn(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        vn(0, 1, 3, mk(1, 0, 0, 0, 0, 0, 0, 0));
        vn(0, 1, 4, mk(2, 1, 1, 0, 0, 0, 0, 0));
        vn(0, 1, 5, mk(2, 1, 1, 0, 0, 0, 0, 0));
        vn(1, 1, 6, mk(0, 0, 0, 0, 0, 0, 0, 0));
        vn(0, 1, 1, mk(1, 0, 0, 0, 0, 0, 0, 0));
        vn(0, 1, 2, mk(2, 1, 1, 0, 0, 0, 0, 0));

        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
